// File: rtl/bp_be_pkg.sv
// Shared back-end types and helpers for the hardware thread scheduler and
// the thread-pick arbiter.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_sched_run,
    e_sched_drain,
    e_sched_idle
  } bp_be_thread_sched_state_e;

  // ID width that stays at least one bit wide for degenerate thread counts.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (a + b) mod n, valid whenever a + b < 2n; avoids a divider in hardware.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/bp_be_thread_rr_pick.sv
// Round-robin next-ready picker: scans ready threads starting after the current
// ID, the current thread considered last. Purely combinational; reusable for FE.
module bp_be_thread_rr_pick
  import bp_be_pkg::*;
#(
  parameter int num_threads_p     = 4,
  parameter int thread_id_width_p = safe_clog2(num_threads_p)
) (
  input  logic [num_threads_p-1:0]     ready_i,
  input  logic [thread_id_width_p-1:0] cur_id_i,
  output logic [thread_id_width_p-1:0] pick_id_o,
  output logic                         pick_v_o
);

  logic [num_threads_p-1:0]     w_rot;
  logic [thread_id_width_p-1:0] w_enc;

  // Rotate so bit 0 is thread cur+1 and the top bit is the current thread.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < num_threads_p; i++) begin
      w_rot[i] = ready_i[thread_id_width_p'(wrap_add(32'(cur_id_i), 32'(i + 1),
                                                     32'(num_threads_p)))];
    end
  end

  always_comb begin
    w_enc = '0;
    for (int i = num_threads_p - 1; i >= 0; i--) begin
      if (w_rot[i]) w_enc = thread_id_width_p'(i);
    end
  end

  assign pick_id_o = thread_id_width_p'(wrap_add(32'(cur_id_i), 32'(w_enc) + 32'd1,
                                                 32'(num_threads_p)));
  assign pick_v_o  = |ready_i;

endmodule

// File: rtl/bp_be_thread_rr_scheduler.sv
// Hardware thread scheduler: picks the active thread on quantum expiry, block,
// not-ready or CTXT CSR write, and commits each switch after a pipeline drain.
module bp_be_thread_rr_scheduler
  import bp_be_pkg::*;
#(
  parameter int num_threads_p     = 4,
  parameter int thread_id_width_p = safe_clog2(num_threads_p),
  parameter int quantum_width_p   = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  input  logic [quantum_width_p-1:0]   quantum_i,
  input  logic [num_threads_p-1:0]     thread_ready_i,
  input  logic                         thread_block_i,
  input  logic                         csr_write_ctxt_v_i,
  input  logic [thread_id_width_p-1:0] csr_write_ctxt_data_i,
  input  logic                         pipe_drained_i,
  output logic [thread_id_width_p-1:0] thread_id_o,
  output logic                         switch_req_o,
  output logic                         switch_v_o,
  output logic                         idle_o
);

  bp_be_thread_sched_state_e    r_state, w_state_n;
  logic [thread_id_width_p-1:0] r_thread_id, w_thread_id_n;
  logic [thread_id_width_p-1:0] r_target, w_target_n;
  logic [quantum_width_p-1:0]   r_cnt, w_cnt_n;
  logic                         r_switch_v, w_switch_v_n;

  logic [thread_id_width_p-1:0] w_pick_id, w_run_target;
  logic                         w_pick_v, w_csr_hit, w_q_expire, w_trigger;

  bp_be_thread_rr_pick #(
    .num_threads_p    (num_threads_p),
    .thread_id_width_p(thread_id_width_p)
  ) u_pick (
    .ready_i  (thread_ready_i),
    .cur_id_i (r_thread_id),
    .pick_id_o(w_pick_id),
    .pick_v_o (w_pick_v)
  );

  // Out-of-range CSR IDs are dropped; '>=' keeps a shrunken quantum from wrapping cnt.
  assign w_csr_hit    = csr_write_ctxt_v_i &&
                        (32'(csr_write_ctxt_data_i) < 32'(num_threads_p));
  assign w_q_expire   = (quantum_i != '0) && (r_cnt >= quantum_i - quantum_width_p'(1));
  assign w_trigger    = w_csr_hit ||
                        (en_i && (thread_block_i || !thread_ready_i[r_thread_id] || w_q_expire));
  assign w_run_target = w_csr_hit ? csr_write_ctxt_data_i : w_pick_id;

  always_comb begin
    w_state_n     = r_state;
    w_thread_id_n = r_thread_id;
    w_target_n    = r_target;
    w_cnt_n       = r_cnt;
    w_switch_v_n  = 1'b0;
    unique case (r_state)
      e_sched_run: begin
        if (w_trigger) begin
          if (!w_csr_hit && !w_pick_v) begin
            w_state_n = e_sched_idle;
          end else if (w_run_target == r_thread_id) begin
            w_cnt_n = '0;
          end else begin
            w_target_n = w_run_target;
            w_state_n  = e_sched_drain;
          end
        end else if (en_i && (quantum_i != '0)) begin
          w_cnt_n = r_cnt + quantum_width_p'(1);
        end
      end
      e_sched_drain: begin
        if (w_csr_hit) w_target_n = csr_write_ctxt_data_i;
        if (pipe_drained_i) begin
          w_thread_id_n = w_target_n;
          w_cnt_n       = '0;
          w_switch_v_n  = 1'b1;
          w_state_n     = e_sched_run;
        end
      end
      e_sched_idle: begin
        if (w_csr_hit) begin
          w_target_n = csr_write_ctxt_data_i;
          w_state_n  = e_sched_drain;
        end else if (w_pick_v) begin
          w_target_n = w_pick_id;
          w_state_n  = e_sched_drain;
        end
      end
      default: w_state_n = e_sched_run;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= e_sched_run;
      r_thread_id <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      r_switch_v  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_thread_id <= w_thread_id_n;
      r_target    <= w_target_n;
      r_cnt       <= w_cnt_n;
      r_switch_v  <= w_switch_v_n;
    end
  end

  assign thread_id_o  = r_thread_id;
  assign switch_req_o = (r_state == e_sched_drain);
  assign switch_v_o   = r_switch_v;
  assign idle_o       = (r_state == e_sched_idle);

endmodule

// File: tb/tb_bp_be_thread_rr_scheduler.sv
// Self-checking bench for bp_be_thread_rr_scheduler: directed scenarios plus
// randomized traffic compared each cycle against a behavioural scheduler model.
module tb_bp_be_thread_rr_scheduler;

  localparam int N = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;

  logic       clk_i = 1'b0;
  logic       reset_n_i, en_i, thread_block_i, csr_write_ctxt_v_i, pipe_drained_i;
  logic [7:0] quantum_i;
  logic [3:0] thread_ready_i;
  logic [2:0] ready3;
  logic [1:0] csr_write_ctxt_data_i;
  logic [1:0] thread_id_o, id3;
  logic       switch_req_o, switch_v_o, idle_o, req3, sv3, idle3;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: current thread, pending target, slice counter, mode.
  int m_mode, m_cur, m_tgt, m_cnt;
  bit m_sv;

  always #5 clk_i = ~clk_i;

  bp_be_thread_rr_scheduler #(.num_threads_p(4), .quantum_width_p(8)) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .quantum_i(quantum_i),
    .thread_ready_i(thread_ready_i), .thread_block_i(thread_block_i),
    .csr_write_ctxt_v_i(csr_write_ctxt_v_i), .csr_write_ctxt_data_i(csr_write_ctxt_data_i),
    .pipe_drained_i(pipe_drained_i), .thread_id_o(thread_id_o),
    .switch_req_o(switch_req_o), .switch_v_o(switch_v_o), .idle_o(idle_o)
  );

  bp_be_thread_rr_scheduler #(.num_threads_p(3), .quantum_width_p(8)) u_dut3 (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .quantum_i(quantum_i),
    .thread_ready_i(ready3), .thread_block_i(thread_block_i),
    .csr_write_ctxt_v_i(csr_write_ctxt_v_i), .csr_write_ctxt_data_i(csr_write_ctxt_data_i),
    .pipe_drained_i(pipe_drained_i), .thread_id_o(id3),
    .switch_req_o(req3), .switch_v_o(sv3), .idle_o(idle3)
  );

  function automatic logic [4:0] obs();
    return {thread_id_o, switch_req_o, switch_v_o, idle_o};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {2'(m_cur), m_mode == M_DRAIN, m_sv, m_mode == M_IDLE};
  endfunction

  function automatic int next_ready(input int cur, input logic [3:0] rdy);
    for (int k = 1; k <= N; k++) if (rdy[(cur + k) % N]) return (cur + k) % N;
    return cur;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_cur = 0; m_tgt = 0; m_cnt = 0; m_sv = 0;
  endtask

  task automatic model_clock();
    bit csr_hit, trig;
    int nr, tgt, q;
    csr_hit = csr_write_ctxt_v_i && (int'(csr_write_ctxt_data_i) < N);
    nr      = next_ready(m_cur, thread_ready_i);
    q       = int'(quantum_i);
    m_sv    = 0;
    case (m_mode)
      M_RUN: begin
        trig = csr_hit || (en_i && (thread_block_i || !thread_ready_i[m_cur] ||
                                    (q != 0 && m_cnt == q - 1)));
        if (trig) begin
          tgt = csr_hit ? int'(csr_write_ctxt_data_i) : nr;
          if (!csr_hit && thread_ready_i == 4'b0) m_mode = M_IDLE;
          else if (tgt == m_cur) m_cnt = 0;
          else begin m_tgt = tgt; m_mode = M_DRAIN; end
        end else if (en_i && q != 0) m_cnt++;
      end
      M_DRAIN: begin
        if (csr_hit) m_tgt = int'(csr_write_ctxt_data_i);
        if (pipe_drained_i) begin m_cur = m_tgt; m_cnt = 0; m_mode = M_RUN; m_sv = 1; end
      end
      default: begin
        if (csr_hit) begin m_tgt = int'(csr_write_ctxt_data_i); m_mode = M_DRAIN; end
        else if (thread_ready_i != 4'b0) begin m_tgt = nr; m_mode = M_DRAIN; end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_clock();
    #1;
  endtask

  task automatic set_defaults();
    en_i = 0; thread_block_i = 0; csr_write_ctxt_v_i = 0; csr_write_ctxt_data_i = 0;
    pipe_drained_i = 1; quantum_i = 0; thread_ready_i = 4'hF; ready3 = 3'h7;
  endtask

  task automatic do_reset();
    set_defaults();
    reset_n_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1;
    model_reset();
  endtask

  task automatic test_reset();
    set_defaults();
    reset_n_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    n_vec++;
    if (obs() !== 5'b00000) begin
      n_mis++; $display("FAIL reset_hold: got=%b exp=00000", obs());
    end
    reset_n_i = 1;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      thread_ready_i = 4'($urandom_range(0, 15));
      thread_block_i = 1'($urandom_range(0, 1));
      quantum_i      = 8'($urandom_range(1, 5));
      tick();
      n_vec++;
      if (thread_id_o !== 2'd0 || switch_req_o !== 1'b0) begin
        n_mis++; $display("FAIL hold_en0 c=%0d: id=%0d req=%b exp id=0 req=0", c, thread_id_o, switch_req_o);
      end
    end
  endtask

  task automatic test_quantum();
    do_reset();
    en_i = 1; quantum_i = 8'd4; thread_ready_i = 4'hF; pipe_drained_i = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if (obs() !== {2'((k / 5) % 4), k % 5 == 4, k % 5 == 0, 1'b0}) begin
        n_mis++; $display("FAIL quantum_seq k=%0d: got=%b exp=%b", k, obs(),
                          {2'((k / 5) % 4), k % 5 == 4, k % 5 == 0, 1'b0});
      end
      n_vec++;
      if (obs() !== exp_vec()) begin
        n_mis++; $display("FAIL quantum_model k=%0d: got=%b exp=%b", k, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_block_skip();
    do_reset();
    en_i = 1; thread_ready_i = 4'b1010; pipe_drained_i = 1;
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd1;
    tick();
    csr_write_ctxt_v_i = 0;
    tick();
    n_vec++;
    if (thread_id_o !== 2'd1 || switch_v_o !== 1'b1) begin
      n_mis++; $display("FAIL block_setup: id=%0d sv=%b exp id=1 sv=1", thread_id_o, switch_v_o);
    end
    thread_block_i = 1; pipe_drained_i = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      thread_block_i = 0;
      n_vec++;
      if (switch_req_o !== 1'b1 || thread_id_o !== 2'd1) begin
        n_mis++; $display("FAIL block_drain_hold c=%0d: req=%b id=%0d exp req=1 id=1", c, switch_req_o, thread_id_o);
      end
    end
    pipe_drained_i = 1;
    tick();
    n_vec++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 1'b0}) begin
      n_mis++; $display("FAIL block_commit3: got=%b exp=11010", obs());
    end
    thread_block_i = 1;
    tick();
    thread_block_i = 0;
    tick();
    n_vec++;
    if (thread_id_o !== 2'd1 || obs() !== exp_vec()) begin
      n_mis++; $display("FAIL block_wrap: got=%b exp=%b (id 1)", obs(), exp_vec());
    end
  endtask

  task automatic test_csr_override();
    do_reset();
    en_i = 1; pipe_drained_i = 0;
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd2;
    tick();
    csr_write_ctxt_data_i = 2'd3;
    tick();
    csr_write_ctxt_v_i = 0; pipe_drained_i = 1;
    tick();
    n_vec++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 1'b0}) begin
      n_mis++; $display("FAIL csr_last_wins: got=%b exp=11010", obs());
    end
    quantum_i = 8'd6;
    repeat (3) tick();
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd3;
    tick();
    csr_write_ctxt_v_i = 0;
    n_vec++;
    if (switch_req_o !== 1'b0 || thread_id_o !== 2'd3) begin
      n_mis++; $display("FAIL csr_same_id: req=%b id=%0d exp req=0 id=3", switch_req_o, thread_id_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (switch_req_o !== (i == 5) || obs() !== exp_vec()) begin
        n_mis++; $display("FAIL csr_cnt_reset i=%0d: got=%b exp=%b", i, obs(), exp_vec());
      end
    end
    // Three-thread instance: ID 3 is out of range and must be dropped.
    do_reset();
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd3;
    tick();
    csr_write_ctxt_v_i = 0;
    tick();
    n_vec++;
    if ({id3, req3, sv3} !== 4'b0000) begin
      n_mis++; $display("FAIL csr_out_of_range: got=%b exp=0000", {id3, req3, sv3});
    end
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd2;
    tick();
    csr_write_ctxt_v_i = 0;
    n_vec++;
    if (req3 !== 1'b1) begin
      n_mis++; $display("FAIL csr3_valid_req: got=%b exp=1", req3);
    end
    tick();
    n_vec++;
    if ({id3, req3, sv3} !== 4'b1001) begin
      n_mis++; $display("FAIL csr3_valid_commit: got=%b exp=1001", {id3, req3, sv3});
    end
  endtask

  task automatic test_idle();
    do_reset();
    en_i = 1; thread_ready_i = 4'b0001;
    tick();
    thread_ready_i = 4'b0000;
    tick();
    n_vec++;
    if (idle_o !== 1'b1 || switch_req_o !== 1'b0) begin
      n_mis++; $display("FAIL idle_enter: idle=%b req=%b exp idle=1 req=0", idle_o, switch_req_o);
    end
    tick();
    thread_ready_i = 4'b0100;
    tick();
    n_vec++;
    if (obs() !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL idle_wake: got=%b exp=00100", obs());
    end
    tick();
    n_vec++;
    if (obs() !== {2'd2, 1'b0, 1'b1, 1'b0} || obs() !== exp_vec()) begin
      n_mis++; $display("FAIL idle_commit: got=%b exp=10010", obs());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd1;
    tick();
    csr_write_ctxt_v_i = 0;
    tick();
    pipe_drained_i = 0; csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd2;
    tick();
    csr_write_ctxt_v_i = 0;
    n_vec++;
    if (obs() !== {2'd1, 1'b1, 1'b0, 1'b0}) begin
      n_mis++; $display("FAIL async_pre: got=%b exp=01100", obs());
    end
    #3 reset_n_i = 0;
    #1;
    n_vec++;
    if (obs() !== 5'b00000) begin
      n_mis++; $display("FAIL async_clear: got=%b exp=00000", obs());
    end
    model_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1; pipe_drained_i = 1;
    tick();
    n_vec++;
    if (obs() !== 5'b00000) begin
      n_mis++; $display("FAIL async_no_stale: got=%b exp=00000", obs());
    end
    csr_write_ctxt_v_i = 1; csr_write_ctxt_data_i = 2'd3;
    tick();
    csr_write_ctxt_v_i = 0;
    tick();
    n_vec++;
    if (obs() !== {2'd3, 1'b0, 1'b1, 1'b0} || obs() !== exp_vec()) begin
      n_mis++; $display("FAIL async_restart: got=%b exp=11010", obs());
    end
  endtask

  task automatic test_random();
    int qs[4] = '{0, 1, 3, 7};
    for (int s = 0; s < 4; s++) begin
      do_reset();
      quantum_i = 8'(qs[s]);
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 3) == 0) thread_ready_i = 4'($urandom_range(0, 15));
        en_i                  = ($urandom_range(0, 7) != 0);
        thread_block_i        = ($urandom_range(0, 9) == 0);
        csr_write_ctxt_v_i    = ($urandom_range(0, 11) == 0);
        csr_write_ctxt_data_i = 2'($urandom_range(0, 3));
        pipe_drained_i        = 1'($urandom_range(0, 1));
        tick();
        n_vec++;
        if (obs() !== exp_vec()) begin
          n_mis++; $display("FAIL random q=%0d c=%0d: got=%b exp=%b", qs[s], c, obs(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    reset_n_i = 0;
    set_defaults();
    model_reset();
    test_reset();
    test_quantum();
    test_block_skip();
    test_csr_override();
    test_idle();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
